// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide EX-stage control logic:
// controller state encoding and the accumulate-operation codes.
package muldiv_pkg;

  localparam int unsigned ACC_W = 2;

  // Controller states: IDLE waits for a request, WAIT owns an in-flight product,
  // DRAIN lets the multiplier drop res_valid, KILL swallows a flushed product.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_KILL  = 2'd3
  } mul_state_e;

  localparam logic [ACC_W-1:0] ACC_NONE = 2'b00;
  localparam logic [ACC_W-1:0] ACC_MADD = 2'b01;
  localparam logic [ACC_W-1:0] ACC_MSUB = 2'b10;

  // Map the reserved encoding onto a plain overwrite so it can never accumulate.
  function automatic logic [ACC_W-1:0] acc_sanitize(input logic [ACC_W-1:0] op);
    logic [ACC_W-1:0] res;
    res = ACC_NONE;
    if (op == ACC_MADD) res = ACC_MADD;
    if (op == ACC_MSUB) res = ACC_MSUB;
    return res;
  endfunction

endpackage

// File: rtl/hilo_reg.sv
// Architectural HI/LO register pair.
// A multiply commit has priority over MTHI/MTLO writes in the same cycle.
// With HILO_MADD_EN defined, a commit can add/subtract the product to/from {HI,LO}.
module hilo_reg
  import muldiv_pkg::*;
#(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] HILO_RST_VAL = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               commit_i,
  input  logic [2*WIDTH-1:0] result_i,
`ifdef HILO_MADD_EN
  input  logic [ACC_W-1:0]   acc_op_i,
`endif
  input  logic               hi_we_i,
  input  logic               lo_we_i,
  input  logic [WIDTH-1:0]   wdata_i,
  output logic [WIDTH-1:0]   hi_o,
  output logic [WIDTH-1:0]   lo_o
);

  localparam int unsigned PW = 2 * WIDTH;

  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [PW-1:0]    commit_val;

  // Next HI/LO: commit value (optionally accumulated) beats MTHI/MTLO.
  always_comb begin
    hi_d       = hi_q;
    lo_d       = lo_q;
    commit_val = result_i;
`ifdef HILO_MADD_EN
    case (acc_op_i)
      ACC_MADD: commit_val = PW'({hi_q, lo_q} + result_i);
      ACC_MSUB: commit_val = PW'({hi_q, lo_q} - result_i);
      default:  commit_val = result_i;
    endcase
`endif
    if (commit_i) begin
      hi_d = commit_val[PW-1:WIDTH];
      lo_d = commit_val[WIDTH-1:0];
    end else begin
      if (hi_we_i) hi_d = wdata_i;
      if (lo_we_i) lo_d = wdata_i;
    end
  end

  // HI/LO storage with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hi_q <= HILO_RST_VAL;
      lo_q <= HILO_RST_VAL;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

  // The pipeline stalls EX until commit, so MTHI/MTLO can never meet a commit.
  a_no_mt_on_commit : assert property (@(posedge clk) disable iff (!rst)
    !(commit_i && (hi_we_i || lo_we_i)));

endmodule

// File: rtl/mult_hilo_ctrl.sv
// EX-stage controller for MULT/MULTU: issues operands to the external iterative
// multiplier, stalls the pipeline until the product lands in HI/LO, and serves MTHI/MTLO.
// Optional feature macro HILO_MADD_EN adds ex_acc_op and MADD/MSUB accumulation.
module mult_hilo_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] HILO_RST_VAL = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ex_mult_req,
  input  logic               ex_sign,
  input  logic [WIDTH-1:0]   ex_a,
  input  logic [WIDTH-1:0]   ex_b,
  input  logic               ex_mthi,
  input  logic               ex_mtlo,
  input  logic [WIDTH-1:0]   ex_wdata,
`ifdef HILO_MADD_EN
  input  logic [ACC_W-1:0]   ex_acc_op,
`endif
  input  logic               flush,
  output logic               stall_req,
  output logic               mult_opn_valid,
  output logic [WIDTH-1:0]   mult_a,
  output logic [WIDTH-1:0]   mult_b,
  output logic               mult_sign,
  input  logic               mult_res_valid,
  output logic               mult_res_ready,
  input  logic [2*WIDTH-1:0] mult_result,
  output logic [WIDTH-1:0]   hi_o,
  output logic [WIDTH-1:0]   lo_o,
  output logic               busy
);

  mul_state_e state_q;
`ifdef HILO_MADD_EN
  logic [ACC_W-1:0] acc_q;
`endif

  logic st_idle, st_wait, st_drain, st_kill;
  logic issue, commit;
  logic hi_we, lo_we;

  // State decode shared by the handshake and stall equations.
  assign st_idle  = (state_q == ST_IDLE);
  assign st_wait  = (state_q == ST_WAIT);
  assign st_drain = (state_q == ST_DRAIN);
  assign st_kill  = (state_q == ST_KILL);

  // Outputs are forced low while reset is asserted.
  assign issue  = rst && st_idle && ex_mult_req && !flush;
  assign commit = rst && st_wait && mult_res_valid;

  // Controller FSM: the multiplier cannot be aborted, so a flushed product is drained in KILL.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
`ifdef HILO_MADD_EN
      acc_q   <= ACC_NONE;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (issue) begin
            state_q <= ST_WAIT;
`ifdef HILO_MADD_EN
            acc_q   <= acc_sanitize(ex_acc_op);
`endif
          end
        end
        ST_WAIT: begin
          if (mult_res_valid)  state_q <= ST_DRAIN;
          else if (flush)      state_q <= ST_KILL;
        end
        ST_DRAIN: begin
          if (!mult_res_valid) state_q <= ST_IDLE;
        end
        ST_KILL: begin
          if (mult_res_valid)  state_q <= ST_DRAIN;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Multiplier handshake; operands pass straight through from EX.
  assign mult_opn_valid = issue;
  assign mult_res_ready = rst && (st_wait || st_kill);
  assign mult_a         = ex_a;
  assign mult_b         = ex_b;
  assign mult_sign      = ex_sign;

  // Hold IF..EX from issue until the commit cycle, and keep a new request waiting while draining.
  assign stall_req = rst && ((st_idle && ex_mult_req && !flush) ||
                             (st_wait && !mult_res_valid) ||
                             ((st_drain || st_kill) && ex_mult_req));

  assign busy = !st_idle;

  // MTHI/MTLO from a flushed instruction must not retire.
  assign hi_we = ex_mthi && !flush;
  assign lo_we = ex_mtlo && !flush;

  hilo_reg #(
    .WIDTH        (WIDTH),
    .HILO_RST_VAL (HILO_RST_VAL)
  ) u_hilo_reg (
    .clk      (clk),
    .rst      (rst),
    .commit_i (commit),
    .result_i (mult_result),
`ifdef HILO_MADD_EN
    .acc_op_i (acc_q),
`endif
    .hi_we_i  (hi_we),
    .lo_we_i  (lo_we),
    .wdata_i  (ex_wdata),
    .hi_o     (hi_o),
    .lo_o     (lo_o)
  );

endmodule
